// File: rtl/reg_file_param.sv
// Parametrised 2R/1W register file with a hardware clear sequencer.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_param #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              write,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic [ADDR_W-1:0] ReadAddrB,
  output logic [WIDTH-1:0]  DataOutputA,
  output logic [WIDTH-1:0]  DataOutputB,
  output logic              ready,
  output logic              WriteDropped
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_drop;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic w_run;
  logic w_wa_ok;
  logic w_ra_ok;
  logic w_rb_ok;
  logic w_wr_ok;
  logic w_drop;

  assign w_run   = (r_state == RUN);
  assign w_wa_ok = {1'b0, WriteAddress} < LIM;
  assign w_ra_ok = {1'b0, ReadAddrA} < LIM;
  assign w_rb_ok = {1'b0, ReadAddrB} < LIM;
  assign w_wr_ok = write && w_run && !clear && w_wa_ok;
  assign w_drop  = write && !w_wr_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      INIT: begin
        if (r_ptr == LAST) begin
          w_state_nxt = RUN;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      RUN: begin
        if (clear) begin
          w_state_nxt = INIT;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
      r_ptr   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_drop  <= w_drop;
    end
  end

  // No reset on the array so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_run)
        r_mem[r_ptr] <= '0;
      else if (w_wr_ok)
        r_mem[WriteAddress] <= WriteData;
    end
  end

  always_comb begin
    DataOutputA = '0;
    DataOutputB = '0;
    if (w_run && w_ra_ok)
      DataOutputA = r_mem[ReadAddrA];
    if (w_run && w_rb_ok)
      DataOutputB = r_mem[ReadAddrB];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && ReadAddrA == WriteAddress)
      DataOutputA = WriteData;
    if (w_wr_ok && ReadAddrB == WriteAddress)
      DataOutputB = WriteData;
`endif
  end

  assign ready        = w_run;
  assign WriteDropped = r_drop;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a 16-deep and a 12-deep instance.
// Random traffic on the 16-deep file is checked against a simple model.
module tb_reg_file_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, wr, rdy, drp;
  logic [3:0]  wa, ra, rb;
  logic [15:0] wd, oa, ob;

  logic        rst_c, clr_c, wr_c, rdy_c, drp_c;
  logic [3:0]  wa_c, ra_c, rb_c;
  logic [15:0] wd_c, oa_c, ob_c;

  int n_chk = 0;
  int n_err = 0;
  int n;
  logic [15:0] m [16];
  logic [15:0] ea, eb, byp;

  reg_file_param #(.WIDTH(16), .DEPTH(16)) u16 (
    .clk(clk), .reset(rst), .clear(clr), .write(wr),
    .WriteAddress(wa), .WriteData(wd),
    .ReadAddrA(ra), .ReadAddrB(rb),
    .DataOutputA(oa), .DataOutputB(ob),
    .ready(rdy), .WriteDropped(drp)
  );

  reg_file_param #(.WIDTH(16), .DEPTH(12)) u12 (
    .clk(clk), .reset(rst_c), .clear(clr_c), .write(wr_c),
    .WriteAddress(wa_c), .WriteData(wd_c),
    .ReadAddrA(ra_c), .ReadAddrB(rb_c),
    .DataOutputA(oa_c), .DataOutputB(ob_c),
    .ready(rdy_c), .WriteDropped(drp_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input bit c12, output int cnt);
    cnt = 0;
    while ((c12 ? rdy_c : rdy) !== 1'b1 && cnt < 40) begin
      if (c12) chk("init_out12", 32'(oa_c), 32'h0);
      else     chk("init_out", 32'(oa), 32'h0);
      tick();
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clr = 0; wr = 0; wa = 0; wd = 0; ra = 0; rb = 0;
    rst_c = 1; clr_c = 0; wr_c = 0; wa_c = 0; wd_c = 0;
    ra_c = 0; rb_c = 0;
`ifdef REGFILE_BYPASS_EN
    byp = 16'h2025;
`else
    byp = 16'h0000;
`endif

    tick();
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_drop", 32'(drp), 32'h0);
    chk("rst_oa", 32'(oa), 32'h0);
    chk("rst_ob", 32'(ob), 32'h0);
    rst = 0;
    wait_rdy(0, n);
    chk("init_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); rb = 4'(15 - i); #1;
      chk("zero_a", 32'(oa), 32'h0);
      chk("zero_b", 32'(ob), 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      wr = 1; wa = 4'(i); wd = 16'hFFFF; tick();
    end
    wr = 0; ra = 3; #1;
    chk("preload", 32'(oa), 32'hFFFF);

    rst = 1; tick(); rst = 0;
    chk("reinit_ready", 32'(rdy), 32'h0);
    ra = 15;
    for (int k = 0; k < 2; k++) begin
      #1 chk("init_force0", 32'(oa), 32'h0);
      tick();
    end
    wr = 1; wa = 9; wd = 16'h5678; tick(); wr = 0;
    chk("init_drop", 32'(drp), 32'h1);
    tick();
    chk("drop_1cyc", 32'(drp), 32'h0);
    tick(); tick();
    rst = 1; tick(); rst = 0;
    chk("midinit_ready", 32'(rdy), 32'h0);
    wait_rdy(0, n);
    chk("restart_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); #1;
      chk("cleared", 32'(oa), 32'h0);
    end

    wr = 1; wa = 5; wd = 16'h2025; ra = 5; rb = 5; #1;
    chk("same_cyc_a", 32'(oa), 32'(byp));
    chk("same_cyc_b", 32'(ob), 32'(byp));
    tick(); wr = 0; #1;
    chk("wr_next_a", 32'(oa), 32'h2025);
    chk("wr_next_b", 32'(ob), 32'h2025);
    chk("wr_nodrop", 32'(drp), 32'h0);

    for (int i = 1; i <= 4; i++) begin
      wr = 1; wa = 4'(i); wd = 16'h1111; tick();
    end
    wr = 0; ra = 2; rb = 4; #1;
    chk("w1111_a", 32'(oa), 32'h1111);
    chk("w1111_b", 32'(ob), 32'h1111);
    clr = 1; wr = 1; wa = 6; wd = 16'hABCD; ra = 6; rb = 5; #1;
    chk("clr_nobyp", 32'(oa), 32'h0);
    chk("clr_old", 32'(ob), 32'h2025);
    tick(); clr = 0; wr = 0;
    chk("clr_ready", 32'(rdy), 32'h0);
    chk("clr_drop", 32'(drp), 32'h1);
    wait_rdy(0, n);
    chk("clr_len", 32'(n), 32'd16);
    for (int i = 1; i <= 6; i++) begin
      ra = 4'(i); #1;
      chk("post_clr", 32'(oa), 32'h0);
    end

    tick(); rst_c = 0;
    wait_rdy(1, n);
    chk("d12_len", 32'(n), 32'd12);
    wr_c = 1; wa_c = 0; wd_c = 16'hA000; tick();
    wa_c = 11; wd_c = 16'hB011; tick();
    chk("d12_okdrop", 32'(drp_c), 32'h0);
    wa_c = 13; wd_c = 16'hBEEF; tick(); wr_c = 0;
    chk("d12_oor_drop", 32'(drp_c), 32'h1);
    ra_c = 13; rb_c = 12; #1;
    chk("d12_oor_a", 32'(oa_c), 32'h0);
    chk("d12_oor_b", 32'(ob_c), 32'h0);
    ra_c = 11; rb_c = 0; #1;
    chk("d12_r11", 32'(oa_c), 32'hB011);
    chk("d12_r0", 32'(ob_c), 32'hA000);
    ra_c = 1; rb_c = 10; #1;
    chk("d12_r1", 32'(oa_c), 32'h0);
    chk("d12_r10", 32'(ob_c), 32'h0);
    clr_c = 1; tick(); clr_c = 0;
    wait_rdy(1, n);
    chk("d12_clr_len", 32'(n), 32'd12);
    ra_c = 11; #1;
    chk("d12_clr_r11", 32'(oa_c), 32'h0);

    for (int i = 0; i < 16; i++) m[i] = 16'h0;
    for (int c = 0; c < 220; c++) begin
      wr = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = 16'($urandom);
      ra = 4'($urandom_range(0, 15));
      rb = (c % 5 == 0) ? wa : 4'($urandom_range(0, 15));
      #1;
      ea = m[ra];
      eb = m[rb];
`ifdef REGFILE_BYPASS_EN
      if (wr && wa == ra) ea = wd;
      if (wr && wa == rb) eb = wd;
`endif
      chk("rnd_a", 32'(oa), 32'(ea));
      chk("rnd_b", 32'(ob), 32'(eb));
      tick();
      chk("rnd_drop", 32'(drp), 32'h0);
      if (wr) m[wa] = wd;
    end
    wr = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
